maxpool2x2_stream: RTL and testbench

- Streaming 2x2 stride-2 max-pooling stage directly downstream of the ReLU activation.
- Consumes one signed activation per accepted cycle, in row-major raster order of an IMG_W x IMG_H feature map.
- Emits one pooled value per 2x2 window, in row-major order of the (IMG_W/2) x (IMG_H/2) output map.
- Input handshake matches the ReLU output pair (Y/valid); there is no backpressure.

---
 rtl/maxpool2x2_stream_pkg.sv | 32 +++
 rtl/maxpool_line_buf.sv | 29 ++
 rtl/maxpool2x2_stream.sv | 120 ++++++++++++
 tb/tb_maxpool2x2_stream.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool2x2_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maxpool2x2_stream_pkg                                                      |
// | Shared CNN definitions: activation width/type, signed_max, clog2 helpers.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package maxpool2x2_stream_pkg;

  localparam int CNN_D_W = 8;
  localparam int CMP_W   = 32;

  typedef logic signed [CNN_D_W-1:0] act_t;
  typedef logic signed [CMP_W-1:0]   cmp_t;

  // Operands are sign-extended to CMP_W so any stage up to 32 bits can share this.
  function automatic cmp_t signed_max(input cmp_t a, input cmp_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int idx_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/maxpool_line_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maxpool_line_buf                                                           |
// | Unreset single-write-port buffer with combinational indexed read.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module maxpool_line_buf #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/maxpool2x2_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maxpool2x2_stream                                                          |
// | Streaming 2x2 stride-2 max pool; optional frame_done via                   |
// | MAXPOOL2X2_FRAME_DONE_EN.                                                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module maxpool2x2_stream
  import maxpool2x2_stream_pkg::*;
#(
  parameter int D_W   = CNN_D_W,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic signed [D_W-1:0] in_data,
  output logic                  out_valid,
  output logic signed [D_W-1:0] out_data
`ifdef MAXPOOL2X2_FRAME_DONE_EN
  ,
  output logic                  frame_done
`endif
);

  localparam int LB_DEPTH = IMG_W / 2;
  localparam int LB_AW    = idx_w(LB_DEPTH);
  localparam int CW       = idx_w(IMG_W);
  localparam int RW       = idx_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]         col_cnt_q, col_cnt_d;
  logic [RW-1:0]         row_cnt_q, row_cnt_d;
  logic signed [D_W-1:0] h_reg_q, h_reg_d;
  logic signed [D_W-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  w_col_last, w_row_last, w_lb_we;
  logic [LB_AW-1:0]      w_lb_idx;
  logic signed [D_W-1:0] w_hmax, w_vmax, w_lb_rdata;
`ifdef MAXPOOL2X2_FRAME_DONE_EN
  logic                  frame_done_q, frame_done_d;
`endif

  assign w_col_last = (col_cnt_q == COL_LAST);
  assign w_row_last = (row_cnt_q == ROW_LAST);
  assign w_lb_idx   = LB_AW'(col_cnt_q >> 1);
  assign w_hmax     = D_W'(signed_max(cmp_t'(h_reg_q), cmp_t'(in_data)));
  assign w_vmax     = D_W'(signed_max(cmp_t'(w_lb_rdata), cmp_t'(w_hmax)));
  // Even rows park their horizontal pair maxima for the odd row below.
  assign w_lb_we    = in_valid & col_cnt_q[0] & ~row_cnt_q[0] & ~rst;

  maxpool_line_buf #(
    .DEPTH (LB_DEPTH),
    .WIDTH (D_W),
    .AW    (LB_AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (w_lb_we),
    .waddr (w_lb_idx),
    .wdata (w_hmax),
    .raddr (w_lb_idx),
    .rdata (w_lb_rdata)
  );

  always_comb begin
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    h_reg_d     = h_reg_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
`ifdef MAXPOOL2X2_FRAME_DONE_EN
    frame_done_d = 1'b0;
`endif
    if (in_valid) begin
      col_cnt_d = w_col_last ? '0 : col_cnt_q + CW'(1);
      if (w_col_last) row_cnt_d = w_row_last ? '0 : row_cnt_q + RW'(1);
      if (!col_cnt_q[0]) begin
        h_reg_d = in_data;
      end else if (row_cnt_q[0]) begin
        out_data_d  = w_vmax;
        out_valid_d = 1'b1;
`ifdef MAXPOOL2X2_FRAME_DONE_EN
        frame_done_d = w_col_last & w_row_last;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      h_reg_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef MAXPOOL2X2_FRAME_DONE_EN
      frame_done_q <= 1'b0;
`endif
    end else begin
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      h_reg_q     <= h_reg_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef MAXPOOL2X2_FRAME_DONE_EN
      frame_done_q <= frame_done_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef MAXPOOL2X2_FRAME_DONE_EN
  assign frame_done = frame_done_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_maxpool2x2_stream.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_maxpool2x2_stream                                                       |
// | Scoreboard bench: 4x4 and 6x2 instances against a window-max model.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_maxpool2x2_stream;

  localparam int D_W = 8;

  typedef struct {
    int     val;
    longint cyc;
    bit     last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0;
  logic signed [D_W-1:0] d0 = '0, d1 = '0;
  logic ov0, ov1;
  logic signed [D_W-1:0] od0, od1;
`ifdef MAXPOOL2X2_FRAME_DONE_EN
  logic fd0, fd1;
`endif

  maxpool2x2_stream #(.D_W(D_W), .IMG_W(4), .IMG_H(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_data(d0),
    .out_valid(ov0), .out_data(od0)
`ifdef MAXPOOL2X2_FRAME_DONE_EN
    , .frame_done(fd0)
`endif
  );

  maxpool2x2_stream #(.D_W(D_W), .IMG_W(6), .IMG_H(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1),
    .out_valid(ov1), .out_data(od1)
`ifdef MAXPOOL2X2_FRAME_DONE_EN
    , .frame_done(fd1)
`endif
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  logic   rst_at_edge = 1'b1;
  logic signed [D_W-1:0] prev_od0 = '0;

  int   img_w [2] = '{4, 6};
  int   img_h [2] = '{4, 2};
  int   img [2][8][8];
  int   pix_k [2] = '{0, 0};
  exp_t q0 [$];
  exp_t q1 [$];

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: store the frame as a 2-D image and emit the window max when its
  // bottom-right pixel arrives.
  task automatic model_accept(input int sel, input int v, input longint acc);
    int   x, y, m;
    exp_t e;
    x = pix_k[sel] % img_w[sel];
    y = (pix_k[sel] / img_w[sel]) % img_h[sel];
    img[sel][y][x] = v;
    if ((x % 2 == 1) && (y % 2 == 1)) begin
      m = img[sel][y-1][x-1];
      for (int dy = 0; dy < 2; dy++)
        for (int dx = 0; dx < 2; dx++)
          if (img[sel][y-dy][x-dx] > m) m = img[sel][y-dy][x-dx];
      e.val  = m;
      e.cyc  = acc;
      e.last = (x == img_w[sel] - 1) && (y == img_h[sel] - 1);
      if (sel == 0) q0.push_back(e); else q1.push_back(e);
    end
    pix_k[sel] = (pix_k[sel] + 1) % (img_w[sel] * img_h[sel]);
  endtask

  task automatic drive(input int sel, input int v);
    @(posedge clk); #1;
    rst = 1'b0;
    v0  = (sel == 0);
    v1  = (sel == 1);
    if (sel == 0) d0 = D_W'(v); else d1 = D_W'(v);
    model_accept(sel, v, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rst = 1'b0;
      v0  = 1'b0;
      v1  = 1'b0;
    end
  endtask

  // Inputs stay valid during reset: those pixels must be dropped.
  task automatic do_reset(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rst = 1'b1;
      v0  = 1'b1;
      v1  = 1'b1;
      d0  = D_W'($urandom_range(0, 255));
      d1  = D_W'($urandom_range(0, 255));
    end
    pix_k = '{0, 0};
  endtask

  task automatic check_port(input int sel, input logic ov, input logic signed [D_W-1:0] od,
                            input logic fd);
    exp_t e;
    n_checks++;
    if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
      n_fail++;
      $display("FAIL dut%0d_unexpected_out: got out_valid=%0d data=%0d, expected no output", sel, ov, od);
    end else begin
      e = (sel == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("dut%0d_data", sel), od, e.val);
      check($sformatf("dut%0d_latency_cycle", sel), cyc, e.cyc);
`ifdef MAXPOOL2X2_FRAME_DONE_EN
      check($sformatf("dut%0d_frame_done", sel), fd, e.last);
`else
      if (fd) $display("dut%0d unexpected fd input", sel);
`endif
    end
  endtask

  always @(negedge clk) begin
    if (rst_at_edge) begin
      check("reset_out_valid0", ov0, 0);
      check("reset_out_data0", od0, 0);
      check("reset_out_valid1", ov1, 0);
      check("reset_out_data1", od1, 0);
    end else begin
      if (ov0) begin
`ifdef MAXPOOL2X2_FRAME_DONE_EN
        check_port(0, ov0, od0, fd0);
`else
        check_port(0, ov0, od0, 1'b0);
`endif
      end else begin
        check("dut0_data_hold", od0, prev_od0);
`ifdef MAXPOOL2X2_FRAME_DONE_EN
        check("dut0_frame_done_idle", fd0, 0);
`endif
      end
      if (ov1) begin
`ifdef MAXPOOL2X2_FRAME_DONE_EN
        check_port(1, ov1, od1, fd1);
`else
        check_port(1, ov1, od1, 1'b0);
`endif
      end
    end
    prev_od0 = od0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);

    // Basic raster 0..15 -> 5, 7, 13, 15
    for (int p = 0; p < 16; p++) drive(0, p);
    idle(3);

    // Signed window {-3,-1 | -7,-2}, rest -128
    for (int p = 0; p < 16; p++) begin
      case (p)
        0: drive(0, -3);
        1: drive(0, -1);
        4: drive(0, -7);
        5: drive(0, -2);
        default: drive(0, -128);
      endcase
    end
    idle(2);

    // Gapped: strict toggling then random idle runs
    for (int p = 0; p < 16; p++) begin
      drive(0, p);
      if (p < 8) idle(1); else idle($urandom_range(0, 3));
    end
    idle(3);

    // Reset mid-frame, short of completing the first window
    for (int p = 0; p < 5; p++) drive(0, 50 + p);
    do_reset(2);
    for (int p = 0; p < 16; p++) drive(0, p);
    idle(2);

    // Back-to-back frames
    for (int p = 0; p < 16; p++) drive(0, p);
    for (int p = 0; p < 16; p++) drive(0, 100 + p);
    idle(2);

    // Random frames with random gaps
    for (int f = 0; f < 4; f++)
      for (int p = 0; p < 16; p++) begin
        drive(0, int'($urandom_range(0, 255)) - 128);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    idle(3);

    // Non-square 6x2: 0..11 -> 7, 9, 11, then random frames
    for (int p = 0; p < 12; p++) drive(1, p);
    for (int f = 0; f < 3; f++)
      for (int p = 0; p < 12; p++) begin
        drive(1, int'($urandom_range(0, 255)) - 128);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
    idle(2);

    for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    check("dut0_outputs_missing", q0.size(), 0);
    check("dut1_outputs_missing", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
